// File: rtl/soc_poll_pkg.sv
// Shared types and Avalon-MM constants for polled-PIO read masters.
package soc_poll_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } poll_state_t;

   localparam int AVM_DATA_WIDTH = 32;

endpackage

// File: rtl/switch_debounce.sv
// Debounces a polled sample vector: a new value must be seen DEBOUNCE_CNT
// consecutive times before it becomes the stable state; edges pulse for one cycle.
module switch_debounce #(
   parameter int WIDTH        = 1,
   parameter int DEBOUNCE_CNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);

   logic [WIDTH-1:0] candidate_reg, candidate_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] state_reg, rise_reg, fall_reg;
   logic [WIDTH-1:0] rise_next, fall_next;
   logic             accept;

   always_comb begin
      candidate_next = candidate_reg;
      count_next     = count_reg;
      accept         = 1'b0;
      if (sample_valid) begin
         if (sample != candidate_reg) begin
            candidate_next = sample;
            count_next     = CNT_W'(1);
         end else if (count_reg != CNT_MAX) begin
            count_next = count_reg + 1'b1;
         end
         accept = (count_next == CNT_MAX) && (candidate_next != state_reg);
      end
   end

   // Edge pulses compare the newly accepted value against the state being replaced.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign rise_next[gi] = accept &  candidate_next[gi] & ~state_reg[gi];
      assign fall_next[gi] = accept & ~candidate_next[gi] &  state_reg[gi];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         candidate_reg <= '0;
         count_reg     <= '0;
         state_reg     <= '0;
         rise_reg      <= '0;
         fall_reg      <= '0;
      end else begin
         candidate_reg <= candidate_next;
         count_reg     <= count_next;
         if (accept) begin
            state_reg <= candidate_next;
         end
         rise_reg <= rise_next;
         fall_reg <= fall_next;
      end
   end

   assign state = state_reg;
   assign rise  = rise_reg;
   assign fall  = fall_reg;

endmodule

// File: rtl/avm_switch_poller.sv
// Avalon-MM read master that periodically polls a switch PIO, guards each read
// with a timeout and hands the sampled bits to a debouncer.
module avm_switch_poller
   import soc_poll_pkg::*;
#(
   parameter int PIO_ADDR       = 0,
   parameter int ADDR_WIDTH     = 2,
   parameter int SAMPLE_BITS    = 1,
   parameter int POLL_DIV       = 50000,
   parameter int DEBOUNCE_CNT   = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic [ADDR_WIDTH-1:0]     avm_address,
   output logic                      avm_read,
   input  logic                      avm_waitrequest,
   input  logic [AVM_DATA_WIDTH-1:0] avm_readdata,
   input  logic                      avm_readdatavalid,
   output logic [SAMPLE_BITS-1:0]    sw_state,
   output logic [SAMPLE_BITS-1:0]    sw_rise,
   output logic [SAMPLE_BITS-1:0]    sw_fall,
   output logic                      bus_error,
   input  logic                      err_clr
);

   localparam int TICK_W = $clog2(POLL_DIV);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(POLL_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

   poll_state_t               state_reg, state_next;
   logic [TICK_W-1:0]         tick_reg;
   logic                      pending_reg;
   logic [TO_W-1:0]           to_cnt_reg;
   logic                      bus_error_reg;
   logic [SAMPLE_BITS-1:0]    sample_reg;
   logic                      sample_valid_reg;
   logic                      tick_wrap, start, capture, timeout, to_last;
   logic [AVM_DATA_WIDTH-1:0] unused_readdata;

   assign avm_address     = ADDR_WIDTH'(PIO_ADDR);
   assign unused_readdata = avm_readdata;
   assign tick_wrap       = enable && (tick_reg == TICK_LAST);
   assign to_last         = (to_cnt_reg == TO_LAST);

   // A wrap in the same cycle the FSM consumes pending re-arms it: it is a new tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_reg    <= '0;
         pending_reg <= 1'b0;
      end else if (!enable) begin
         tick_reg    <= '0;
         pending_reg <= 1'b0;
      end else begin
         tick_reg <= tick_wrap ? '0 : tick_reg + 1'b1;
         if (tick_wrap) begin
            pending_reg <= 1'b1;
         end else if (start) begin
            pending_reg <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      start      = 1'b0;
      capture    = 1'b0;
      timeout    = 1'b0;
      avm_read   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pending_reg && enable) begin
               state_next = REQ;
               start      = 1'b1;
            end
         end
         REQ: begin
            avm_read = 1'b1;
            if (!avm_waitrequest && avm_readdatavalid) begin
               capture    = 1'b1;
               state_next = IDLE;
            end else if (to_last) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end else if (!avm_waitrequest) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (avm_readdatavalid) begin
               capture    = 1'b1;
               state_next = IDLE;
            end else if (to_last) begin
               timeout    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_reg       <= '0;
         bus_error_reg    <= 1'b0;
         sample_reg       <= '0;
         sample_valid_reg <= 1'b0;
      end else begin
         to_cnt_reg       <= (state_reg == IDLE) ? '0 : to_cnt_reg + 1'b1;
         sample_valid_reg <= capture;
         if (capture) begin
            sample_reg <= avm_readdata[SAMPLE_BITS-1:0];
         end
         if (timeout) begin
            bus_error_reg <= 1'b1;
         end else if (err_clr) begin
            bus_error_reg <= 1'b0;
         end
      end
   end

   assign bus_error = bus_error_reg;

   switch_debounce #(
      .WIDTH        (SAMPLE_BITS),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid_reg),
      .sample       (sample_reg),
      .state        (sw_state),
      .rise         (sw_rise),
      .fall         (sw_fall)
   );

endmodule

// File: tb/tb_avm_switch_poller.sv
// Self-checking bench for avm_switch_poller: directed vector table, random polls
// against a window-based debounce model, and timeout/enable/reset sequences.
module tb_avm_switch_poller;

   localparam int DC = 3;

   logic        clk = 1'b0;
   logic        reset, enable, err_clr;
   logic        avm_waitrequest, avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic [1:0]  avm_address;
   logic        avm_read, bus_error;
   logic [0:0]  sw_state, sw_rise, sw_fall;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int txn = 0;
   int rise_q[$];
   logic hist[$];
   logic prev_read = 1'b0;

   typedef struct {
      int   wr;
      int   lat;
      logic data;
      logic st;
      logic ri;
      logic fa;
   } vec_t;
   vec_t tbl[16];

   avm_switch_poller #(
      .PIO_ADDR       (0),
      .ADDR_WIDTH     (2),
      .SAMPLE_BITS    (1),
      .POLL_DIV       (8),
      .DEBOUNCE_CNT   (DC),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .sw_state          (sw_state),
      .sw_rise           (sw_rise),
      .sw_fall           (sw_fall),
      .bus_error         (bus_error),
      .err_clr           (err_clr)
   );

   always #5 clk = ~clk;

   // Cycle counter and log of the cycle index at which each read request starts.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (avm_read && !prev_read) rise_q.push_back(cyc);
      prev_read = avm_read;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Debounced state after the first n samples: the value of the most recent
   // window of DC identical consecutive samples, or 0 if no such window exists.
   function automatic logic model_state(input int n);
      for (int k = n - 1; k >= DC - 1; k--) begin
         logic same = 1'b1;
         for (int j = 1; j < DC; j++) if (hist[k-j] !== hist[k]) same = 1'b0;
         if (same) return hist[k];
      end
      return 1'b0;
   endfunction

   task automatic drive_rdv(input logic data);
      avm_readdatavalid = 1'b1;
      avm_readdata      = $urandom();
      avm_readdata[0]   = data;
   endtask

   task automatic wait_read();
      int n = 0;
      while (avm_read !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_bit("read_issued", avm_read, 1'b1);
   endtask

   // Serves one read: stall wr cycles, return data lat cycles after acceptance.
   task automatic serve(input int wr, input int lat, input logic data, input bit drop_en,
                        output logic st, output logic ri, output logic fa);
      wait_read();
      if (drop_en) enable = 1'b0;
      for (int i = 0; i < wr; i++) begin
         avm_waitrequest = 1'b1;
         @(negedge clk);
         check_bit("read_held", avm_read, 1'b1);
         check_int("addr_held", int'(avm_address), 0);
      end
      avm_waitrequest = 1'b0;
      if (lat == 0) drive_rdv(data);
      @(negedge clk);
      avm_waitrequest   = 1'b1;
      avm_readdatavalid = 1'b0;
      check_bit("read_released", avm_read, 1'b0);
      if (lat > 0) begin
         repeat (lat - 1) @(negedge clk);
         drive_rdv(data);
         @(negedge clk);
         avm_readdatavalid = 1'b0;
      end
      hist.push_back(data);
      @(negedge clk);
      st = sw_state[0];
      ri = sw_rise[0];
      fa = sw_fall[0];
      @(negedge clk);
      check_bit("rise_one_cycle", sw_rise[0], 1'b0);
      check_bit("fall_one_cycle", sw_fall[0], 1'b0);
      txn++;
      $display("txn %0d: wr=%0d lat=%0d data=%b -> state=%b rise=%b fall=%b",
               txn, wr, lat, data, st, ri, fa);
   endtask

   task automatic serve_model(input int wr, input int lat, input logic data, input bit drop_en);
      logic st, ri, fa, e_now, e_prev;
      serve(wr, lat, data, drop_en, st, ri, fa);
      e_now  = model_state(hist.size());
      e_prev = model_state(hist.size() - 1);
      check_bit("model_state", st, e_now);
      check_bit("model_rise", ri, e_now & ~e_prev);
      check_bit("model_fall", fa, ~e_now & e_prev);
   endtask

   // Accepts a read but never answers it, then offers a late, ignored response.
   task automatic do_timeout();
      int n, r;
      logic lv;
      wait_read();
      r = rise_q[$];
      avm_waitrequest = 1'b0;
      @(negedge clk);
      avm_waitrequest = 1'b1;
      check_bit("to_read_dropped", avm_read, 1'b0);
      n = 0;
      while (bus_error !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check_int("to_error_cycle", cyc - r, 16);
      check_bit("to_idle_read", avm_read, 1'b0);
      lv = ~model_state(hist.size());
      drive_rdv(lv);
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      $display("timeout: bus_error after %0d cycles, late data %b offered", cyc - r, lv);
   endtask

   initial begin
      logic st, ri, fa, d;
      int nrise, n0, n;

      tbl[0]  = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{0, 1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6]  = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{0, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{0, 1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{5, 1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{5, 0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{2, 0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[15] = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b1};

      reset = 1'b1; enable = 1'b1; err_clr = 1'b0;
      avm_waitrequest = 1'b1; avm_readdatavalid = 1'b0; avm_readdata = '0;
      repeat (3) @(negedge clk);
      check_bit("rst_read", avm_read, 1'b0);
      check_bit("rst_state", sw_state[0], 1'b0);
      check_bit("rst_rise", sw_rise[0], 1'b0);
      check_bit("rst_fall", sw_fall[0], 1'b0);
      check_bit("rst_error", bus_error, 1'b0);
      reset = 1'b0;
      rise_q.delete();

      for (int i = 0; i < 16; i++) begin
         serve(tbl[i].wr, tbl[i].lat, tbl[i].data, 1'b0, st, ri, fa);
         check_bit("tbl_state", st, tbl[i].st);
         check_bit("tbl_rise", ri, tbl[i].ri);
         check_bit("tbl_fall", fa, tbl[i].fa);
         if (tbl[i].wr != 0) check_bit("tbl_no_error", bus_error, 1'b0);
         if (i == 2) begin
            check_int("poll_period_1", rise_q[1] - rise_q[0], 8);
            check_int("poll_period_2", rise_q[2] - rise_q[1], 8);
         end
      end

      d = model_state(hist.size());
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) d = ~d;
         serve_model($urandom_range(0, 3), $urandom_range(0, 3), d, 1'b0);
      end

      do_timeout();
      d = ~model_state(hist.size());
      for (int i = 0; i < 3; i++) serve_model(0, 1, d, 1'b0);
      check_bit("error_sticky", bus_error, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check_bit("error_cleared", bus_error, 1'b0);

      serve_model(3, 1, ~d, 1'b1);
      nrise = rise_q.size();
      repeat (20) @(negedge clk);
      check_int("no_read_disabled", rise_q.size(), nrise);
      check_int("tick_held", int'(dut.tick_reg), 0);
      enable = 1'b1;
      n0 = cyc;
      n = 0;
      while (rise_q.size() == nrise && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_int("reenable_first_read", rise_q[$] - n0, 9);
      serve_model(0, 1, ~d, 1'b0);

      for (int i = 0; i < 3; i++) serve_model(0, 1, 1'b1, 1'b0);
      do_timeout();
      check_bit("pre_rst_state", sw_state[0], 1'b1);
      check_bit("pre_rst_error", bus_error, 1'b1);
      wait_read();
      avm_waitrequest = 1'b0;
      @(negedge clk);
      avm_waitrequest = 1'b1;
      reset = 1'b1;
      #1;
      check_bit("midrst_read", avm_read, 1'b0);
      check_bit("midrst_state", sw_state[0], 1'b0);
      check_bit("midrst_error", bus_error, 1'b0);
      check_bit("midrst_rise", sw_rise[0], 1'b0);
      hist.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive_rdv(1'b1);
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      for (int i = 0; i < 3; i++) serve_model(0, 1, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
